// File: rtl/pmesh_mem_responder_if.sv
// rtl/pmesh_mem_responder_if.sv - L2 <-> memory request/msg3 handshake bundle
interface pmesh_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_type;
   logic [25:0] req_tag;
   logic [5:0]  req_source;
   logic [63:0] req_data;
   logic        msg3_valid;
   logic        msg3_ready;
   logic [7:0]  msg3_type;
   logic [25:0] msg3_tag;
   logic [5:0]  msg3_source;
   logic [63:0] msg3_data;

   // L2 side: issues requests, consumes responses
   modport master (
      output req_valid, req_type, req_tag, req_source, req_data, msg3_ready,
      input  req_ready, msg3_valid, msg3_type, msg3_tag, msg3_source, msg3_data
   );

   // Memory side: accepts requests, produces responses
   modport slave (
      input  req_valid, req_type, req_tag, req_source, req_data, msg3_ready,
      output req_ready, msg3_valid, msg3_type, msg3_tag, msg3_source, msg3_data
   );
endinterface

// File: rtl/pmesh_mem_responder.sv
// rtl/pmesh_mem_responder.sv - PMESH memory endpoint model (optional counters: PMESH_MEM_STATS_EN)
module pmesh_mem_responder #(
   parameter int ADDR_BITS = 4,
   parameter int LATENCY   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   pmesh_mem_responder_if.slave   bus,
`ifdef PMESH_MEM_STATS_EN
   output logic [15:0]            load_cnt,
   output logic [15:0]            store_cnt,
`endif
   output logic                   err_unsupported
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [7:0] T_LOAD   = 8'h13;
   localparam logic [7:0] T_STORE  = 8'h14;
   localparam logic [7:0] T_LACK   = 8'h18;
   localparam logic [7:0] T_SACK   = 8'h19;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t         state;
   logic [3:0]     cnt;
   logic [7:0]     lat_type;
   logic [25:0]    lat_tag;
   logic [5:0]     lat_source;
   logic [63:0]    lat_data;
   logic [63:0]    mem [2**ADDR_BITS];

   logic                 accept;
   logic                 last_wait;
   logic [ADDR_BITS-1:0] idx;

   assign accept    = bus.req_valid && bus.req_ready;
   assign last_wait = (state == WAIT) && (cnt == 4'd0);
   assign idx       = lat_tag[ADDR_BITS-1:0];

   // Backing store: uninitialised; the store commits on the final WAIT edge
   always_ff @(posedge clk) begin
      if (last_wait && lat_type == T_STORE)
         mem[idx] <= lat_data;
   end

   // Request/response FSM with registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         lat_type        <= 8'd0;
         lat_tag         <= 26'd0;
         lat_source      <= 6'd0;
         lat_data        <= 64'd0;
         bus.req_ready   <= 1'b0;
         bus.msg3_valid  <= 1'b0;
         bus.msg3_type   <= 8'd0;
         bus.msg3_tag    <= 26'd0;
         bus.msg3_source <= 6'd0;
         bus.msg3_data   <= 64'd0;
         err_unsupported <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.req_ready <= 1'b1;
               if (accept) begin
                  if (bus.req_type == T_LOAD || bus.req_type == T_STORE) begin
                     lat_type      <= bus.req_type;
                     lat_tag       <= bus.req_tag;
                     lat_source    <= bus.req_source;
                     lat_data      <= bus.req_data;
                     cnt           <= CNT_INIT;
                     bus.req_ready <= 1'b0;
                     state         <= WAIT;
                  end else begin
                     // Swallowed silently apart from the sticky flag
                     err_unsupported <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state           <= RESP;
                  bus.msg3_valid  <= 1'b1;
                  bus.msg3_type   <= (lat_type == T_LOAD) ? T_LACK : T_SACK;
                  bus.msg3_tag    <= lat_tag;
                  bus.msg3_source <= lat_source;
                  bus.msg3_data   <= (lat_type == T_LOAD) ? mem[idx] : 64'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (bus.msg3_ready) begin
                  bus.msg3_valid <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PMESH_MEM_STATS_EN
   // Saturating completion counters, bumped on the msg3 handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_cnt  <= 16'd0;
         store_cnt <= 16'd0;
      end else if (bus.msg3_valid && bus.msg3_ready) begin
         if (bus.msg3_type == T_LACK && load_cnt != 16'hFFFF)
            load_cnt <= load_cnt + 16'd1;
         if (bus.msg3_type == T_SACK && store_cnt != 16'hFFFF)
            store_cnt <= store_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pmesh_mem_responder.sv
// tb/tb_pmesh_mem_responder.sv - self-checking bench for pmesh_mem_responder
module tb_pmesh_mem_responder;
   localparam int LAT = 3;
   localparam logic [7:0] T_LOAD = 8'h13, T_STORE = 8'h14, T_LACK = 8'h18, T_SACK = 8'h19;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic err;
`ifdef PMESH_MEM_STATS_EN
   logic [15:0] load_cnt, store_cnt;
`endif

   pmesh_mem_responder_if bus ();

   pmesh_mem_responder #(.ADDR_BITS(4), .LATENCY(LAT)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
`ifdef PMESH_MEM_STATS_EN
      .load_cnt        (load_cnt),
      .store_cnt       (store_cnt),
`endif
      .err_unsupported (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: word store indexed by tag[3:0], with a written flag
   logic [63:0] m_mem [16];
   logic        m_vld [16];
   logic        m_err = 1'b0;
   int          m_loads = 0;
   int          m_stores = 0;

   typedef struct {
      logic [7:0]  t;
      logic [25:0] tag;
      logic [5:0]  src;
      logic [63:0] d;
      int          hold;
      logic [7:0]  et;
      logic [63:0] ed;
      logic        chk;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.req_ready && n < 20) begin
         tick();
         n++;
      end
      check("req_ready_idle", bus.req_ready, 1);
   endtask

   task automatic txn(input logic [7:0] t, input logic [25:0] tag, input logic [5:0] src,
                      input logic [63:0] d, input int hold, input logic [7:0] et,
                      input logic [63:0] ed, input logic chk);
      int n;
      logic [103:0] snap;
      logic supported;
      supported = (t == T_LOAD || t == T_STORE);
      wait_ready();
      bus.msg3_ready = (hold == 0);
      bus.req_type   = t;
      bus.req_tag    = tag;
      bus.req_source = src;
      bus.req_data   = d;
      bus.req_valid  = 1'b1;
      tick();
      if (!supported) begin
         bus.req_valid = 1'b0;
         m_err = 1'b1;
         n = 0;
         repeat (LAT + 4) begin
            if (bus.msg3_valid) n++;
            tick();
         end
         check("no_resp_unsup", n, 0);
      end else begin
         // Keep presenting a bogus request while busy; it must be ignored
         bus.req_type   = T_LOAD;
         bus.req_tag    = 26'($urandom);
         bus.req_source = 6'($urandom);
         bus.req_data   = {$urandom, $urandom};
         n = 0;
         while (!bus.msg3_valid && n < 40) begin
            tick();
            n++;
         end
         check("latency", n, LAT);
         check("msg3_type", bus.msg3_type, et);
         check("msg3_tag", bus.msg3_tag, tag);
         check("msg3_source", bus.msg3_source, src);
         if (chk) check("msg3_data", bus.msg3_data, ed);
         snap = {bus.msg3_type, bus.msg3_tag, bus.msg3_source, bus.msg3_data};
         for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_stable",
                  {bus.msg3_valid, bus.req_ready, bus.msg3_type, bus.msg3_tag, bus.msg3_source, bus.msg3_data},
                  {1'b1, 1'b0, snap});
         end
         bus.msg3_ready = 1'b1;
         tick();
         bus.req_valid = 1'b0;
         check("valid_drop", {bus.msg3_valid, bus.req_ready}, 2'b00);
         tick();
         check("ready_back", {bus.msg3_valid, bus.req_ready}, 2'b01);
         if (t == T_STORE) begin
            m_mem[tag[3:0]] = d;
            m_vld[tag[3:0]] = 1'b1;
            m_stores++;
         end else begin
            m_loads++;
         end
      end
      check("err_unsupported", err, m_err);
   endtask

   initial begin
      logic [7:0]  rt;
      logic [25:0] rtag;
      logic [63:0] rd;
      int          r;
      int          n;

      for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_type   = 8'd0;
      bus.req_tag    = 26'd0;
      bus.req_source = 6'd0;
      bus.req_data   = 64'd0;
      bus.msg3_ready = 1'b1;

      vecs[0] = '{T_STORE, 26'h5,       6'h2,  64'hDEADBEEF_00000001, 0, T_SACK, 64'd0,                 1'b1};
      vecs[1] = '{T_LOAD,  26'h5,       6'h3,  64'd0,                 5, T_LACK, 64'hDEADBEEF_00000001, 1'b1};
      vecs[2] = '{T_STORE, 26'h13,      6'h1,  64'h1,                 0, T_SACK, 64'd0,                 1'b1};
      vecs[3] = '{T_LOAD,  26'h3,       6'h4,  64'd0,                 0, T_LACK, 64'h1,                 1'b1};
      vecs[4] = '{T_STORE, 26'h3FFFFFF, 6'h3F, 64'hAAAA5555_CCCC3333, 2, T_SACK, 64'd0,                 1'b1};
      vecs[5] = '{T_LOAD,  26'h000000F, 6'h10, 64'd0,                 0, T_LACK, 64'hAAAA5555_CCCC3333, 1'b1};
      vecs[6] = '{8'h19,   26'h7,       6'h5,  64'd0,                 0, 8'd0,   64'd0,                 1'b0};
      vecs[7] = '{T_LOAD,  26'h105,     6'h6,  64'd0,                 0, T_LACK, 64'hDEADBEEF_00000001, 1'b1};

      // Reset state
      tick();
      tick();
      check("reset_outputs",
            {bus.req_ready, bus.msg3_valid, bus.msg3_type, bus.msg3_tag, bus.msg3_source, bus.msg3_data, err},
            '0);
      rst = 1'b1;

      for (int i = 0; i < 8; i++)
         txn(vecs[i].t, vecs[i].tag, vecs[i].src, vecs[i].d, vecs[i].hold, vecs[i].et, vecs[i].ed, vecs[i].chk);

      // Reset one cycle into WAIT: store must be dropped, outputs cleared asynchronously
      wait_ready();
      bus.req_type   = T_STORE;
      bus.req_tag    = 26'h5;
      bus.req_source = 6'h9;
      bus.req_data   = 64'h0BAD_0BAD_0BAD_0BAD;
      bus.req_valid  = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check("async_reset_outputs",
            {bus.req_ready, bus.msg3_valid, bus.msg3_type, bus.msg3_tag, bus.msg3_source, bus.msg3_data, err},
            '0);
      m_err = 1'b0;
      m_loads = 0;
      m_stores = 0;
      tick();
      tick();
      rst = 1'b1;
      n = 0;
      repeat (2 * LAT + 4) begin
         tick();
         if (bus.msg3_valid) n++;
      end
      check("no_stale_resp", n, 0);
      check("ready_after_reset", bus.req_ready, 1);
      txn(T_LOAD, 26'h5, 6'h1, 64'd0, 0, T_LACK, m_mem[5], 1'b1);

      // Randomised traffic against the model
      for (int i = 0; i < 40; i++) begin
         r    = $urandom_range(0, 9);
         rtag = 26'($urandom);
         rd   = {$urandom, $urandom};
         if (r == 0) begin
            rt = 8'($urandom_range(0, 255));
            if (rt == T_LOAD || rt == T_STORE) rt = 8'hFF;
            txn(rt, rtag, 6'($urandom), rd, 0, 8'd0, 64'd0, 1'b0);
         end else if (r < 5) begin
            txn(T_LOAD, rtag, 6'($urandom), rd, $urandom_range(0, 3), T_LACK,
                m_mem[rtag[3:0]], m_vld[rtag[3:0]]);
         end else begin
            txn(T_STORE, rtag, 6'($urandom), rd, $urandom_range(0, 3), T_SACK, 64'd0, 1'b1);
         end
      end

`ifdef PMESH_MEM_STATS_EN
      check("load_cnt", load_cnt, m_loads);
      check("store_cnt", store_cnt, m_stores);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
